// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//
// Turns a clean, debounced, clk-synchronous button level into single-cycle
// event pulses for UI/menu logic: press, release, click, double-click,
// long-press and auto-repeat. Every output is registered.
//
// Parameters
//   LONG_CYCLES   cycles held before long_press (>= 2)
//   DCLICK_CYCLES window after a short release for a second press (>= 1)
//   REPEAT_CYCLES auto-repeat period while long-held; 0 disables repeat
//   W_CTR         counter width; 2**W_CTR must cover the largest period
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   i              debounced button level, 1 = pressed
//   pressed        registered copy of i
//   press          pulse on each rising edge of i
//   release_pulse  pulse on each falling edge of i
//   click          pulse: short press with no second press inside the window
//   dclick         pulse: second short press released (with release_pulse)
//   long_press     pulse: held LONG_CYCLES
//   repeat_pulse   pulse every REPEAT_CYCLES while long-held
//
// "release" and "repeat" are reserved words in SystemVerilog, so those two
// event outputs carry a _pulse suffix.
// -----------------------------------------------------------------------------
module button_events #(
  parameter int unsigned LONG_CYCLES   = 500,
  parameter int unsigned DCLICK_CYCLES = 250,
  parameter int unsigned REPEAT_CYCLES = 100,
  parameter int unsigned W_CTR         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic repeat_pulse
);

  // Terminal counts: the counter starts at 0 on state entry, so a timeout of
  // N cycles fires when it reads N-1.
  localparam logic [W_CTR-1:0] LONG_LAST   = W_CTR'(LONG_CYCLES - 1);
  localparam logic [W_CTR-1:0] DCLICK_LAST = W_CTR'(DCLICK_CYCLES - 1);
  localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 0);
  localparam logic [W_CTR-1:0] REPEAT_LAST =
    REPEAT_EN ? W_CTR'(REPEAT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,    // released, no gesture in progress
    PRESS1,  // first press held, not yet long
    WAIT2,   // short press released, waiting for a possible second press
    PRESS2,  // second press held, not yet long
    HOLD     // long-pressed, auto-repeating
  } state_t;

  state_t           state, state_nxt;
  logic [W_CTR-1:0] ctr;
  logic             ctr_clr;
  logic             i_prev;
  logic             rise, fall;

  logic press_nxt, release_nxt, click_nxt, dclick_nxt, long_nxt, repeat_nxt;

  assign rise = i & ~i_prev;
  assign fall = ~i & i_prev;

  // Next-state and pulse decode. Edges are tested before timeouts so that an
  // edge always wins a tie with a counter expiry.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_nxt   = state;
    ctr_clr     = 1'b0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    dclick_nxt  = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          press_nxt = 1'b1;
        end
      end

      PRESS1: begin
        if (fall) begin
          state_nxt   = WAIT2;
          release_nxt = 1'b1;
        end else if (ctr == LONG_LAST) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end
      end

      WAIT2: begin
        if (rise) begin
          state_nxt = PRESS2;
          press_nxt = 1'b1;
        end else if (ctr == DCLICK_LAST) begin
          state_nxt = IDLE;
          click_nxt = 1'b1;
        end
      end

      PRESS2: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          dclick_nxt  = 1'b1;
        end else if (ctr == LONG_LAST) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end
      end

      HOLD: begin
        // Releasing a long press ends the gesture silently (no click).
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else if (REPEAT_EN && (ctr == REPEAT_LAST)) begin
          repeat_nxt = 1'b1;
          ctr_clr    = 1'b1;  // restart the period without leaving HOLD
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register, cycle counter, edge history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ctr           <= '0;
      i_prev        <= 1'b0;
      pressed       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      dclick        <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would make results depend on order.
      state <= state_nxt;
      if ((state_nxt != state) || ctr_clr) begin
        ctr <= '0;
      end else begin
        ctr <= ctr + W_CTR'(1);
      end
      i_prev        <= i;
      pressed       <= i;
      press         <= press_nxt;
      release_pulse <= release_nxt;
      click         <= click_nxt;
      dclick        <= dclick_nxt;
      long_press    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

endmodule

// File: tb/tb_button_events.sv
// -----------------------------------------------------------------------------
// tb_button_events
//
// Drives button_events (LONG=8, DCLICK=4, REPEAT=3) with directed and random
// button waveforms. Each waveform is a list of per-cycle levels; expected
// pulses are derived from the run lengths of that list (how long each press
// lasted and how long the gap before it was), then compared cycle by cycle.
// Output vector order: {pressed, press, release, click, dclick, long, repeat}.
// -----------------------------------------------------------------------------
module tb_button_events;

  localparam int LONG  = 8;
  localparam int DCL   = 4;
  localparam int REP   = 3;
  localparam int MAXN  = 512;
  localparam int TAIL  = DCL + 3;

  localparam int B_PRESSED = 6;
  localparam int B_PRESS   = 5;
  localparam int B_RELEASE = 4;
  localparam int B_CLICK   = 3;
  localparam int B_DCLICK  = 2;
  localparam int B_LONG    = 1;
  localparam int B_REPEAT  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic i     = 1'b0;
  logic pressed, press, release_pulse, click, dclick, long_press, repeat_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  bit         lvl [MAXN];
  logic [6:0] expv[MAXN];
  int         n_lvl;
  int         obs_cnt[7];

  button_events #(
    .LONG_CYCLES  (LONG),
    .DCLICK_CYCLES(DCL),
    .REPEAT_CYCLES(REP),
    .W_CTR        (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i            (i),
    .pressed      (pressed),
    .press        (press),
    .release_pulse(release_pulse),
    .click        (click),
    .dclick       (dclick),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {pressed, press, release_pulse, click, dclick, long_press, repeat_pulse};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void add_run(input bit level, input int len);
    for (int k = 0; k < len; k++) begin
      if (n_lvl < MAXN) begin
        lvl[n_lvl] = level;
        n_lvl++;
      end
    end
  endfunction

  function automatic void set_ev(input int idx, input int b);
    if (idx >= 0 && idx < n_lvl) expv[idx][b] = 1'b1;
  endfunction

  // Gesture model: each high run starting at sample r with length L is
  // classified from L and the low gap before it. A run longer than LONG
  // samples is a long press; a short run following a short first press
  // within DCL low samples is a double click; a short first press not
  // followed in time becomes a click DCL samples after its release.
  function automatic void build_expected();
    int  s, r, len, last_fall;
    bit  waiting, second;
    for (int k = 0; k < n_lvl; k++) begin
      bit prev;
      prev    = (k == 0) ? 1'b0 : lvl[k-1];
      expv[k] = '0;
      expv[k][B_PRESSED] = lvl[k];
      expv[k][B_PRESS]   = lvl[k] & ~prev;
      expv[k][B_RELEASE] = ~lvl[k] & prev;
    end
    s         = 0;
    waiting   = 1'b0;
    last_fall = 0;
    while (s < n_lvl) begin
      if (!lvl[s]) begin
        s++;
      end else begin
        r   = s;
        len = 0;
        while ((r + len < n_lvl) && lvl[r + len]) len++;
        second = waiting && ((r - last_fall) <= DCL);
        if (waiting && !second) set_ev(last_fall + DCL, B_CLICK);
        waiting = 1'b0;
        if (len >= LONG + 1) begin
          set_ev(r + LONG, B_LONG);
          for (int t = r + LONG + REP; t < r + len; t += REP) set_ev(t, B_REPEAT);
        end else if (r + len < n_lvl) begin
          if (second) begin
            set_ev(r + len, B_DCLICK);
          end else begin
            waiting   = 1'b1;
            last_fall = r + len;
          end
        end
        s = r + len;
      end
    end
    if (waiting) set_ev(last_fall + DCL, B_CLICK);
  endfunction

  // Caller is positioned just after a falling clock edge; sample k is taken
  // at the k-th following rising edge and checked on the next falling edge.
  task automatic run_seq(input string name);
    logic [6:0] o;
    build_expected();
    for (int b = 0; b < 7; b++) obs_cnt[b] = 0;
    i = lvl[0];
    for (int s = 0; s < n_lvl; s++) begin
      @(negedge clk);
      o = outs();
      for (int b = 0; b < 7; b++) if (b != B_PRESSED && o[b]) obs_cnt[b]++;
      check($sformatf("%s[%0d]", name, s), o, expv[s]);
      if (s + 1 < n_lvl) i = lvl[s + 1];
    end
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    i     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hold", outs(), 7'b0);
    rst_n = 1'b1;

    // Idle after reset: nothing fires.
    n_lvl = 0; add_run(0, 20);
    run_seq("reset_idle");

    // Single click: press t, release t+3, click t+7.
    n_lvl = 0; add_run(1, 3); add_run(0, TAIL);
    run_seq("single_click");
    check("single_click_count", 7'(obs_cnt[B_CLICK]), 7'd1);
    check("single_click_dclick", 7'(obs_cnt[B_DCLICK]), 7'd0);

    // Double click.
    n_lvl = 0; add_run(1, 2); add_run(0, 2); add_run(1, 2); add_run(0, TAIL);
    run_seq("double_click");
    check("double_click_dclick", 7'(obs_cnt[B_DCLICK]), 7'd1);
    check("double_click_click", 7'(obs_cnt[B_CLICK]), 7'd0);
    check("double_click_press", 7'(obs_cnt[B_PRESS]), 7'd2);

    // Long hold of 15 cycles: long at +8, repeat at +11 and +14.
    n_lvl = 0; add_run(1, 15); add_run(0, TAIL);
    run_seq("long_hold");
    check("long_hold_repeats", 7'(obs_cnt[B_REPEAT]), 7'd2);
    check("long_hold_long", 7'(obs_cnt[B_LONG]), 7'd1);
    check("long_hold_click", 7'(obs_cnt[B_CLICK]), 7'd0);

    // Hold boundary: 8 samples is short, 9 is long.
    n_lvl = 0; add_run(1, LONG); add_run(0, TAIL);
    run_seq("hold_8");
    check("hold_8_long", 7'(obs_cnt[B_LONG]), 7'd0);
    check("hold_8_click", 7'(obs_cnt[B_CLICK]), 7'd1);
    n_lvl = 0; add_run(1, LONG + 1); add_run(0, TAIL);
    run_seq("hold_9");
    check("hold_9_long", 7'(obs_cnt[B_LONG]), 7'd1);
    check("hold_9_click", 7'(obs_cnt[B_CLICK]), 7'd0);

    // Second rise on the click-timeout cycle, and one cycle too late.
    n_lvl = 0; add_run(1, 2); add_run(0, DCL); add_run(1, 2); add_run(0, TAIL);
    run_seq("gap_4");
    check("gap_4_click", 7'(obs_cnt[B_CLICK]), 7'd0);
    check("gap_4_dclick", 7'(obs_cnt[B_DCLICK]), 7'd1);
    n_lvl = 0; add_run(1, 2); add_run(0, DCL + 1); add_run(1, 2); add_run(0, TAIL);
    run_seq("gap_5");
    check("gap_5_click", 7'(obs_cnt[B_CLICK]), 7'd2);

    // Triple press, and a long second press.
    n_lvl = 0;
    add_run(1, 1); add_run(0, 1); add_run(1, 1); add_run(0, 1); add_run(1, 1);
    add_run(0, TAIL);
    run_seq("triple");
    n_lvl = 0; add_run(1, 2); add_run(0, 3); add_run(1, 12); add_run(0, TAIL);
    run_seq("long_second");

    // Random gestures.
    for (int q = 0; q < 40; q++) begin
      n_lvl = 0;
      add_run(0, int'($urandom_range(1, 3)));
      for (int p = 0; p < 4; p++) begin
        add_run(1, int'($urandom_range(1, 14)));
        add_run(0, int'($urandom_range(1, 7)));
      end
      add_run(0, TAIL);
      run_seq($sformatf("rand%0d", q));
    end

    // Reset while in HOLD with the button still down.
    n_lvl = 0; add_run(1, 12);
    run_seq("pre_reset_hold");
    rst_n = 1'b0;
    #1;
    check("reset_hold_async", outs(), 7'b0);
    repeat (2) @(negedge clk);
    check("reset_hold_during", outs(), 7'b0);
    rst_n = 1'b1;
    n_lvl = 0; add_run(1, 10); add_run(0, TAIL);
    run_seq("post_reset_hold");
    check("post_reset_long", 7'(obs_cnt[B_LONG]), 7'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
